// File: rtl/jtcop_snlatch_pkg.sv
// Shared definitions for the main-to-sound command latch: FSM encodings and counter sizing.
package jtcop_snlatch_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_PULSE = PULSE,
    S_GAP   = GAP
  } state_t;

  function automatic int cnt_w(input int len, input int gap);
    return $clog2(((len > gap) ? len : gap) + 1);
  endfunction

endpackage

// File: rtl/jtcop_snlatch_fifo.sv
// Circular command buffer for the sound latch, depth 2**AW. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module jtcop_snlatch_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       last
);

  logic [7:0]  mem [2**AW];
  logic [AW:0] wp, rp;
  logic [AW:0] used;

  assign used  = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign last  = (used == (AW+1)'(1));
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: an empty buffer is never shown on the latch.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtcop_snlatch.sv
// Main-CPU to sound-CPU command latch with NMI pulse generation.
// Define JTCOP_SNLATCH_FIFO_EN to queue commands instead of a single register.
//
// state | meaning
// IDLE  | waiting for a signalled command
// PULSE | snreq held high for NMI_LEN cycles
// GAP   | snreq held low for NMI_GAP cycles before another pulse
module jtcop_snlatch
  import jtcop_snlatch_pkg::*;
#(
  parameter int NMI_LEN = 16,
  parameter int NMI_GAP = 8,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       snd_rd,
  output logic [7:0] latch,
  output logic       snreq,
  output logic       pending,
  output logic       overflow
);

  localparam int CW = cnt_w(NMI_LEN, NMI_GAP);
  localparam logic [CW-1:0] LEN_LD = CW'(NMI_LEN - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(NMI_GAP - 1);

  if (NMI_LEN < 2 || NMI_GAP < 1 || FIFO_AW < 1) begin : g_bad_param
    $error("jtcop_snlatch: NMI_LEN>=2, NMI_GAP>=1, FIFO_AW>=1 required");
  end

  logic main_wr_l, snd_rd_l;
  logic wr_ev, rd_ev;
  logic set_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_wr_l <= 1'b0;
      snd_rd_l  <= 1'b0;
    end else begin
      main_wr_l <= main_wr;
      snd_rd_l  <= snd_rd;
    end
  end

  assign wr_ev = main_wr & ~main_wr_l;
  assign rd_ev = snd_rd_l & ~snd_rd;

`ifdef JTCOP_SNLATCH_FIFO_EN
  logic       empty, full, last;
  logic [7:0] head;
  logic       pop, push_ok, more;

  assign pop     = rd_ev & ~empty;
  assign push_ok = wr_ev & (~full | pop);
  // Entries still queued after a pop each need their own NMI.
  assign more    = pop & (~last | push_ok);

  jtcop_snlatch_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (main_din),
    .head  (head),
    .empty (empty),
    .full  (full),
    .last  (last)
  );

  assign latch    = empty ? 8'd0 : head;
  assign pending  = ~empty;
  assign set_pend = push_ok | more;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   overflow <= 1'b0;
    else if (wr_ev & ~push_ok) overflow <= 1'b1;
  end
`else
  assign set_pend = wr_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch    <= 8'd0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ev) begin
        latch   <= main_din;
        pending <= 1'b1;
        if (pending & ~rd_ev) overflow <= 1'b1;
      end else if (rd_ev) begin
        pending <= 1'b0;
      end
    end
  end
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sig_pend;
  logic          start;

  // A request waiting at the end of the gap starts straight away so the low
  // time between back-to-back pulses is exactly NMI_GAP.
  assign start = sig_pend & ((state == S_IDLE) ||
                             (state == S_GAP && cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      snreq <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_PULSE;
            cnt   <= LEN_LD;
            snreq <= 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state <= S_GAP;
            cnt   <= GAP_LD;
            snreq <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            if (start) begin
              state <= S_PULSE;
              cnt   <= LEN_LD;
              snreq <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          snreq <= 1'b0;
        end
      endcase
    end
  end

  // A new command arriving as the FSM starts must survive for its own pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sig_pend <= 1'b0;
    else if (set_pend) sig_pend <= 1'b1;
    else if (start)    sig_pend <= 1'b0;
  end

endmodule

// File: tb/tb_jtcop_snlatch.sv
// Directed self-checking bench for jtcop_snlatch (register build by default,
// FIFO checks enabled when JTCOP_SNLATCH_FIFO_EN is defined).
module tb_jtcop_snlatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       main_wr;
  logic [7:0] main_din;
  logic       snd_rd;
  logic [7:0] latch;
  logic       snreq;
  logic       pending;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  jtcop_snlatch dut (
    .clk      (clk),
    .rst      (rst),
    .main_wr  (main_wr),
    .main_din (main_din),
    .snd_rd   (snd_rd),
    .latch    (latch),
    .snreq    (snreq),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    main_wr  = 1'b0;
    snd_rd   = 1'b0;
    main_din = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input logic [7:0] d);
    main_din = d;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
  endtask

  task automatic rd_pulse();
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
    tick();
  endtask

  task automatic count_rises(input int n, output int rises);
    int   r = 0;
    logic prev = snreq;
    for (int i = 0; i < n; i++) begin
      tick();
      if (snreq && !prev) r++;
      prev = snreq;
    end
    rises = r;
  endtask

  task automatic test_reset();
    int r;
    do_reset();
    n_cmp++; if (latch !== 8'h00) begin n_bad++; $display("FAIL reset_latch got %h want 00", latch); end
    n_cmp++; if (snreq !== 1'b0) begin n_bad++; $display("FAIL reset_snreq got %b want 0", snreq); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rd_pulse();
    count_rises(30, r);
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL idle_read_pending got %b want 0", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL idle_read_overflow got %b want 0", overflow); end
    n_cmp++; if (r !== 0) begin n_bad++; $display("FAIL idle_read_pulses got %0d want 0", r); end
  endtask

  task automatic test_single_write();
    int lat, h;
    do_reset();
    wr_byte(8'h5A);
    lat = 1;
    while (!snreq && lat < 50) begin tick(); lat++; end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency got %0d want 2", lat); end
    n_cmp++; if (latch !== 8'h5A) begin n_bad++; $display("FAIL wr_latch got %h want 5a", latch); end
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL wr_pending got %b want 1", pending); end
    h = 0;
    while (snreq && h < 100) begin tick(); h++; end
    n_cmp++; if (h !== 16) begin n_bad++; $display("FAIL pulse_width got %0d want 16", h); end
  endtask

  task automatic test_held_write();
    int r1, r2;
    do_reset();
    main_din = 8'h6B;
    main_wr  = 1'b1;
    count_rises(40, r1);
    main_wr  = 1'b0;
    count_rises(40, r2);
    n_cmp++; if (r1 + r2 !== 1) begin n_bad++; $display("FAIL held_wr_pulses got %0d want 1", r1 + r2); end
    rd_pulse();
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL held_rd_pending got %b want 0", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL held_rd_overflow got %b want 0", overflow); end
`ifndef JTCOP_SNLATCH_FIFO_EN
    n_cmp++; if (latch !== 8'h6B) begin n_bad++; $display("FAIL held_rd_latch got %h want 6b", latch); end
`endif
  endtask

  task automatic test_back_to_back();
    int w, l, h, r;
    do_reset();
    wr_byte(8'h11);
    tick(); tick(); tick();
    wr_byte(8'h22);
`ifdef JTCOP_SNLATCH_FIFO_EN
    n_cmp++; if (latch !== 8'h11) begin n_bad++; $display("FAIL b2b_latch got %h want 11", latch); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow got %b want 0", overflow); end
`else
    n_cmp++; if (latch !== 8'h22) begin n_bad++; $display("FAIL b2b_latch got %h want 22", latch); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_overflow got %b want 1", overflow); end
`endif
    w = 0;
    while (snreq && w < 40) begin tick(); w++; end
    l = 0;
    while (!snreq && l < 40) begin tick(); l++; end
    n_cmp++; if (l !== 8) begin n_bad++; $display("FAIL b2b_gap got %0d want 8", l); end
    h = 0;
    while (snreq && h < 40) begin tick(); h++; end
    n_cmp++; if (h !== 16) begin n_bad++; $display("FAIL b2b_second_width got %0d want 16", h); end
    count_rises(40, r);
    n_cmp++; if (r !== 0) begin n_bad++; $display("FAIL b2b_extra_pulses got %0d want 0", r); end
  endtask

`ifdef JTCOP_SNLATCH_FIFO_EN
  task automatic test_fifo_full();
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr_byte(8'(i));
      tick();
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fifo_overflow got %b want 1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      n_cmp++; if (latch !== exp) begin n_bad++; $display("FAIL fifo_head got %h want %h", latch, exp); end
      rd_pulse();
    end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL fifo_drained got %b want 0", pending); end
    n_cmp++; if (latch !== 8'h00) begin n_bad++; $display("FAIL fifo_empty_latch got %h want 00", latch); end
  endtask
`endif

  task automatic test_simultaneous();
    do_reset();
    wr_byte(8'h33);
    tick(); tick();
    snd_rd = 1'b1;
    tick();
    snd_rd   = 1'b0;
    main_din = 8'h44;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL simul_pending got %b want 1", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL simul_overflow got %b want 0", overflow); end
    n_cmp++; if (latch !== 8'h44) begin n_bad++; $display("FAIL simul_latch got %h want 44", latch); end
  endtask

  task automatic test_reset_mid_pulse();
    int r;
    do_reset();
    wr_byte(8'h77);
    tick(); tick(); tick();
    n_cmp++; if (snreq !== 1'b1) begin n_bad++; $display("FAIL mid_pulse_high got %b want 1", snreq); end
    rst = 1'b1;
    #1;
    n_cmp++; if (snreq !== 1'b0) begin n_bad++; $display("FAIL rst_drop_snreq got %b want 0", snreq); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (latch !== 8'h00) begin n_bad++; $display("FAIL rst_latch got %h want 00", latch); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending got %b want 0", pending); end
    count_rises(40, r);
    n_cmp++; if (r !== 0) begin n_bad++; $display("FAIL rst_no_pulse got %0d want 0", r); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_held_write();
    test_back_to_back();
`ifdef JTCOP_SNLATCH_FIFO_EN
    test_fifo_full();
`endif
    test_simultaneous();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
